// File: rtl/idiv_arbiter.sv
// Round-robin two-port arbiter and sequencer for the shared multicycle divider.
// Define DIVZERO_BYPASS_EN to answer divide-by-zero requests locally without issuing them.
module idiv_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req0_signed,
    input  logic                  req0_rem,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic                  req1_signed,
    input  logic                  req1_rem,
    output logic                  req1_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] div_a,
    output logic [DATA_WIDTH-1:0] div_b,
    output logic                  div_signed_ope,
    output logic                  div_write_a,
    output logic                  div_start,
    output logic                  div_flush,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder,
    input  logic                  div_ready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic                  signed_q, signed_d, rem_q, rem_d;
    logic                  grant_q, grant_d, lastGrant_q, lastGrant_d;
    logic                  busy_q;

    logic                  anyValid, grantSel, accept, inOperation;
    logic [DATA_WIDTH-1:0] selA, selB;
    logic                  selSigned, selRem;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        anyValid    = req0_valid | req1_valid;
        grantSel    = (req0_valid & req1_valid) ? ~lastGrant_q : req1_valid;
        accept      = (state_q == IDLE) & anyValid & ~flush & ~reset;
        selA        = grantSel ? req1_a      : req0_a;
        selB        = grantSel ? req1_b      : req0_b;
        selSigned   = grantSel ? req1_signed : req0_signed;
        selRem      = grantSel ? req1_rem    : req0_rem;
        inOperation = (state_q == LOAD) | (state_q == START) | (state_q == WAIT);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        rem_d       = rem_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d         = selA;
                    b_d         = selB;
                    signed_d    = selSigned;
                    rem_d       = selRem;
                    grant_d     = grantSel;
                    lastGrant_d = grantSel;
                    state_d     = LOAD;
`ifdef DIVZERO_BYPASS_EN
                    if (selB == '0) begin
                        result_d = selRem ? selA : '1;
                        state_d  = DONE;
                    end
`endif
                end
            end
            LOAD:    state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (div_ready) begin
                    result_d = rem_q ? div_remainder : div_quotient;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over a result arriving in the same cycle.
        if (flush && inOperation) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            rem_q       <= 1'b0;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            result_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            rem_q       <= rem_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            result_q    <= result_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req0_ready     = accept & ~grantSel;
    assign req1_ready     = accept & grantSel;
    assign resp0_valid    = (state_q == DONE) & ~grant_q;
    assign resp1_valid    = (state_q == DONE) & grant_q;
    assign resp0_data     = resp0_valid ? result_q : '0;
    assign resp1_data     = resp1_valid ? result_q : '0;
    assign busy           = busy_q;
    assign div_a          = a_q;
    assign div_b          = b_q;
    assign div_signed_ope = signed_q;
    assign div_write_a    = (state_q == LOAD);
    assign div_start      = (state_q == START);
    assign div_flush      = flush & inOperation;

endmodule

// File: tb/tb_idiv_arbiter.sv
// Bench for idiv_arbiter: behavioural divider plus a cycle-level transaction model.
// Latency expectations follow DIVZERO_BYPASS_EN when it is defined for the build.
module tb_idiv_arbiter;

    localparam int W      = 32;
    localparam int DivLat = 36;
`ifdef DIVZERO_BYPASS_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 4;
`endif

    logic         clk = 1'b0;
    logic         reset, flush;
    logic         req0_valid, req0_signed, req0_rem, req0_ready;
    logic         req1_valid, req1_signed, req1_rem, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp1_valid, busy;
    logic [W-1:0] resp0_data, resp1_data;
    logic [W-1:0] div_a, div_b, div_quotient, div_remainder;
    logic         div_signed_ope, div_write_a, div_start, div_flush, div_ready;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    idiv_arbiter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed), .req0_rem(req0_rem), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed), .req1_rem(req1_rem), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .busy(busy), .div_a(div_a), .div_b(div_b), .div_signed_ope(div_signed_ope),
        .div_write_a(div_write_a), .div_start(div_start), .div_flush(div_flush),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cycle, actual, expected);
        end
    endtask

    // Truncating division; x/0 gives all ones with remainder x, signed overflow gives x rem 0.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (sgn) begin
            sa = a; sb = b; q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return {q, r};
    endfunction

    // Divider stand-in: dividend on write_a, busy for 32 cycles after a start edge unless b is zero.
    logic [W-1:0] dA, dQ, dR;
    int           dCnt;
    logic         dStartPrev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_ready <= 1'b1; dCnt <= 0; dA <= '0; dQ <= '0; dR <= '0; dStartPrev <= 1'b0;
        end else begin
            dStartPrev <= div_start;
            if (div_flush) begin
                div_ready <= 1'b1; dCnt <= 0;
            end else if (div_start && !dStartPrev) begin
                {dQ, dR} <= refDiv(dA, div_b, div_signed_ope);
                if (div_b != '0) begin
                    dCnt <= 32; div_ready <= 1'b0;
                end
            end else if (dCnt != 0) begin
                dCnt <= dCnt - 1; div_ready <= (dCnt == 1);
            end
            if (div_write_a) dA <= div_a;
        end
    end
    assign div_quotient  = dQ;
    assign div_remainder = dR;

    // Transaction model: one operation at a time, result due a fixed number of cycles after acceptance.
    bit           mBusy = 1'b0;
    bit           mLast = 1'b1;
    int           mAcc = 0, mDue = 0, mPort = 0;
    logic [W-1:0] mData;
    logic         mAccept, mGnt, mLive, mInWork;
    logic [63:0]  qr;
    always @(negedge clk) begin
        mLive   = mBusy && !reset;
        mAccept = !mBusy && !reset && !flush && (req0_valid || req1_valid);
        mGnt    = (req0_valid && req1_valid) ? !mLast : req1_valid;
        mInWork = mLive && cycle > mAcc && cycle < mDue;
        checkOutput("ready0", req0_ready, mAccept && !mGnt);
        checkOutput("ready1", req1_ready, mAccept && mGnt);
        checkOutput("resp0Valid", resp0_valid, mLive && cycle == mDue && mPort == 0);
        checkOutput("resp1Valid", resp1_valid, mLive && cycle == mDue && mPort == 1);
        if (mLive && cycle == mDue)
            checkOutput("respData", (mPort == 1) ? resp1_data : resp0_data, mData);
        checkOutput("busy", busy, mLive && cycle > mAcc);
        checkOutput("divFlush", div_flush, flush && mInWork);
        checkOutput("divStart", div_start, mLive && cycle == mAcc + 2);
        if (reset) begin
            mBusy = 1'b0; mLast = 1'b1;
        end else if (mAccept) begin
            mBusy = 1'b1; mAcc = cycle; mPort = mGnt ? 1 : 0; mLast = mGnt;
            if (mGnt) begin
                qr    = refDiv(req1_a, req1_b, req1_signed);
                mData = req1_rem ? qr[31:0] : qr[63:32];
                mDue  = cycle + ((req1_b == '0) ? ZeroLat : DivLat);
            end else begin
                qr    = refDiv(req0_a, req0_b, req0_signed);
                mData = req0_rem ? qr[31:0] : qr[63:32];
                mDue  = cycle + ((req0_b == '0) ? ZeroLat : DivLat);
            end
        end else if (mBusy && (cycle == mDue || (flush && mInWork))) begin
            mBusy = 1'b0;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitGrant(input int limit, output int port, output int accCyc);
        bit got = 1'b0;
        port = -1; accCyc = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1'b1; port = req1_ready ? 1 : 0; accCyc = cycle;
            end
            nextCycle();
        end
        checkOutput("grantSeen", got, 1);
    endtask

    task automatic applyStimulus(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input logic rem, output int accCyc);
        int p;
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_signed = sgn; req0_rem = rem; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_signed = sgn; req1_rem = rem; req1_valid = 1'b1;
        end
        waitGrant(200, p, accCyc);
        checkOutput("grantPort", p, port);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    endtask

    task automatic waitResp(input int port, input int limit, output logic [W-1:0] d, output int rc);
        bit got = 1'b0;
        d = '0; rc = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? resp0_valid : resp1_valid) begin
                got = 1'b1; d = (port == 0) ? resp0_data : resp1_data; rc = cycle;
            end
            nextCycle();
        end
        checkOutput("respSeen", got, 1);
    endtask

    task automatic randOperands(output logic [W-1:0] a, output logic [W-1:0] b);
        case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = $urandom_range(1, 20);
            default: b = $urandom;
        endcase
        a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
    endtask

    initial begin
        int acc, rc, p, seen;
        logic [W-1:0] d;
        reset = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_signed = 1'b0; req0_rem = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_signed = 1'b0; req1_rem = 1'b0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("resetOutputs", {busy, req0_ready, req1_ready, resp0_valid, resp1_valid, div_start}, 0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        applyStimulus(0, 32'd100, 32'd7, 1'b0, 1'b0, acc);
        waitResp(0, 60, d, rc);
        checkOutput("unsignedQuot", d, 32'd14);
        checkOutput("unsignedLat", rc - acc, DivLat);

        applyStimulus(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, acc);
        waitResp(1, 60, d, rc);
        checkOutput("signedRem", d, 32'hFFFF_FFFF);
        applyStimulus(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, acc);
        waitResp(1, 60, d, rc);
        checkOutput("signedQuot", d, 32'hFFFF_FFFD);

        applyStimulus(0, 32'd123, 32'd0, 1'b0, 1'b0, acc);
        waitResp(0, 60, d, rc);
        checkOutput("divZeroQuot", d, 32'hFFFF_FFFF);
        checkOutput("divZeroLat", rc - acc, ZeroLat);
        applyStimulus(0, 32'd123, 32'd0, 1'b0, 1'b1, acc);
        waitResp(0, 60, d, rc);
        checkOutput("divZeroRem", d, 32'd123);

        // Abort mid-divide at C+10, then confirm the block recovers.
        applyStimulus(0, 32'd5000, 32'd13, 1'b0, 1'b0, acc);
        repeat (9) nextCycle();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flushPulse", div_flush, 1);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flushIdle", busy, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            @(negedge clk);
            if (resp0_valid || resp1_valid) seen++;
        end
        nextCycle();
        checkOutput("flushNoResp", seen, 0);
        applyStimulus(0, 32'd9, 32'd3, 1'b0, 1'b0, acc);
        waitResp(0, 60, d, rc);
        checkOutput("afterFlush", d, 32'd3);

        // Asynchronous reset at C+20 must clear every output at once.
        applyStimulus(1, 32'd777, 32'd5, 1'b0, 1'b0, acc);
        repeat (19) nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("midResetCtl", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
                                    div_flush, div_write_a, div_start, div_signed_ope}, 0);
        checkOutput("midResetData", div_a | div_b | resp0_data | resp1_data, 0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, acc);
        waitResp(0, 60, d, rc);
        checkOutput("afterReset", d, 32'hFFFF_FFF2);
        checkOutput("afterResetLat", rc - acc, DivLat);

        // Both requesters held valid straight out of reset: grants alternate starting with 0.
        reset = 1'b1;
        req0_a = 32'd50; req0_b = 32'd5; req0_signed = 1'b0; req0_rem = 1'b0; req0_valid = 1'b1;
        req1_a = 32'd81; req1_b = 32'd9; req1_signed = 1'b0; req1_rem = 1'b0; req1_valid = 1'b1;
        repeat (2) nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitGrant(100, p, acc);
            checkOutput("rrOrder", p, i % 2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (40) nextCycle();

        for (int n = 0; n < 4000; n++) begin
            req0_valid  = ($urandom_range(0, 2) != 0);
            req1_valid  = ($urandom_range(0, 2) != 0);
            req0_signed = $urandom_range(0, 1) != 0;
            req1_signed = $urandom_range(0, 1) != 0;
            req0_rem    = $urandom_range(0, 1) != 0;
            req1_rem    = $urandom_range(0, 1) != 0;
            randOperands(req0_a, req0_b);
            randOperands(req1_a, req1_b);
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 699) == 0);
            nextCycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (60) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idiv_arbiter.md
# idiv_arbiter

Sequencer and two-port arbiter for the shared multicycle integer divider. It accepts division requests from two requesters, typically the CPU execute stage and a memory-mapped I/O port. It grants one request at a time by round-robin and drives the divider's write-dividend / start-edge protocol. It returns the selected quotient or remainder to the granted requester as a one-cycle response pulse.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the divider instance.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  abort the in-flight operation; no response is issued
- reqN_valid  in  1  request from requester N (N = 0, 1)
- reqN_a  in  DATA_WIDTH  dividend
- reqN_b  in  DATA_WIDTH  divisor
- reqN_signed  in  1  signed operation
- reqN_rem  in  1  1 returns the remainder, 0 returns the quotient
- reqN_ready  out  1  request accepted this cycle (combinational grant)
- respN_valid  out  1  one-cycle result strobe to requester N
- respN_data  out  DATA_WIDTH  result; valid only while respN_valid is high
- busy  out  1  high in any state except IDLE
- div_a, div_b  out  DATA_WIDTH  divider operands
- div_signed_ope, div_write_a, div_start, div_flush  out  1  divider controls
- div_quotient, div_remainder  in  DATA_WIDTH  divider results
- div_ready  in  1  divider idle / result valid

## Operation
- FSM states: IDLE, LOAD, START, WAIT, DONE.
- **IDLE**
  - If any reqN_valid is high, grant one requester and assert its reqN_ready in the same cycle.
  - Latch a, b, signed, rem and the grant index into internal registers; go to LOAD.
- **Round-robin grant**
  - When both requesters are valid, grant the one not granted last.
  - The last-grant register resets to 1, so requester 0 wins first.
  - A single valid request is always granted.
- **LOAD**: div_write_a=1 and div_a=latched a, so the divider captures the dividend; go to START.
- **START**
  - div_start=1, with div_b and div_signed_ope driven from the latched values.
  - div_start is 0 in every other state, so each operation presents exactly one rising edge.
  - Go to WAIT.
- **WAIT**
  - Hold div_b and div_signed_ope stable.
  - When div_ready=1, capture div_remainder if rem else div_quotient into the result register; go to DONE.
- **DONE**
  - respN_valid=1 for the granted N, with respN_data equal to the result register.
  - The other requester's response stays 0. Go to IDLE.
- **flush**
  - In LOAD, START or WAIT: drive div_flush=1 for that cycle and go to IDLE with no response.
  - In IDLE or DONE: ignored; a DONE response still issues.
  - In IDLE, flush also suppresses any grant that cycle.
- **Reset**
  - All outputs go to 0 and the state to IDLE.
  - A request in flight is dropped silently.
  - The divider's own reset is driven separately by the system.
- Operands in the req ports may change after the cycle reqN_ready is high; they are not re-sampled.

## Timing
- Accept cycle C: reqN_ready=1.
- C+1 LOAD, C+2 START.
- Divisor nonzero: div_ready is low during C+3..C+34 and high at C+35, which is captured. respN_valid=1 at C+36.
- Divisor zero (bypass macro absent): div_ready stays high; captured at C+3, respN_valid at C+4.
- Next accept is possible at C+37, or C+5 for the zero-divisor case.
- Between operations div_start is low for at least 2 cycles.
- busy is registered from the state and is high from C+1 through the DONE cycle.

## Configuration
- **DIVZERO_BYPASS_EN defined**
  - A request with b==0 is not issued to the divider: IDLE goes directly to DONE.
  - The quotient result is all ones; the remainder result is a.
  - respN_valid arrives at C+1.
- **DIVZERO_BYPASS_EN undefined**
  - A b==0 request is issued to the divider normally.
  - The result is whatever div_quotient / div_remainder present; the response arrives at C+4.

## Test plan
- req0: a=100, b=7, unsigned, quotient -> reqN_ready at C, resp0_valid at C+36 with data 14; resp1_valid stays 0.
- req1: a=-7 (0xFFFFFFF9), b=2, signed, remainder -> resp1_data=0xFFFFFFFF. Same operands with quotient -> 0xFFFFFFFD.
- Both valid continuously after reset -> grant order 0,1,0,1; each response goes to the correct port with its own operands.
- b=0, a=123, quotient:
  - With the macro: response at C+1 with data 0xFFFFFFFF; remainder request returns 123.
  - Without the macro: response at C+4.
- flush at C+10 -> div_flush pulse, no response, busy low at C+11. A new req0 with 9/3 then returns 3.
- reset asserted at C+20, mid-operation -> all outputs 0 immediately. After release, a new request completes in 36 cycles with a correct result.
